// File: rtl/lcd_row_writer_if.sv
// Bundle between a display-row source and the HD44780 row writer.
// The slave side is the writer: it consumes rows and drives the LCD pins.
interface lcd_row_writer_if;
    logic [127:0] row_1;
    logic [127:0] row_2;
    logic         lcd_en;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [7:0]   lcd_data;
    logic         ready;
    logic         frame_done;

    modport master (
        output row_1, row_2,
        input  lcd_en, lcd_rs, lcd_rw, lcd_data, ready, frame_done
    );

    modport slave (
        input  row_1, row_2,
        output lcd_en, lcd_rs, lcd_rw, lcd_data, ready, frame_done
    );
endinterface

// File: rtl/lcd_row_writer.sv
// Drives a 16x2 HD44780 LCD in 8-bit mode: power-up wait, init commands,
// then a full 34-byte rewrite whenever the two display rows change.
//
// state   | meaning
// POWERUP | waiting for the controller to come out of power-on
// INIT    | writing 0x38, 0x0C, 0x01, 0x06
// IDLE    | ready; watching rows against the last-written snapshot
// FRAME   | writing 0x80, row 1, 0xC0, row 2 from the snapshot
module lcd_row_writer #(
    parameter int E_CYCLES     = 8,
    parameter int CMD_WAIT     = 500,
    parameter int CLEAR_WAIT   = 20000,
    parameter int POWERUP_WAIT = 200000
) (
    input logic             clk_i,
    input logic             rst_i,
    lcd_row_writer_if.slave bus
);

    localparam int MAX_A   = (POWERUP_WAIT > CLEAR_WAIT) ? POWERUP_WAIT : CLEAR_WAIT;
    localparam int MAX_B   = (CMD_WAIT > E_CYCLES) ? CMD_WAIT : E_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] E_LAST     = CW'(E_CYCLES - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT - 1);
    localparam logic [CW-1:0] PU_END     = CW'(POWERUP_WAIT);

    typedef enum logic [1:0] {ST_POWERUP, ST_INIT, ST_IDLE, ST_FRAME} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

    state_t        state_q;
    phase_t        phase_q;
    logic [CW-1:0] cnt_q;
    logic [5:0]    idx_q;
    logic          force_q;
    logic [127:0]  snap1_q;
    logic [127:0]  snap2_q;
    logic          en_q;
    logic          rs_q;
    logic [7:0]    data_q;
    logic          ready_q;
    logic          done_q;

    logic          rows_changed;
    logic [CW-1:0] phase_last;
    logic          phase_end;
    logic          last_byte;
    logic [5:0]    idx_d;
    logic [8:0]    byte_d;

    // Column 0 sits in the top byte of the row.
    function automatic logic [7:0] col_of(input logic [127:0] row, input logic [3:0] c);
        return 8'(row >> {~c, 3'b000});
    endfunction

    function automatic logic [8:0] byte_sel(input logic is_frame, input logic [5:0] idx,
                                            input logic [127:0] r1, input logic [127:0] r2);
        logic [5:0] off;
        logic [8:0] b;
        b = 9'h000;
        if (!is_frame) begin
            case (idx)
                6'd0:    b = {1'b0, 8'h38};
                6'd1:    b = {1'b0, 8'h0C};
                6'd2:    b = {1'b0, 8'h01};
                default: b = {1'b0, 8'h06};
            endcase
        end else if (idx == 6'd0) begin
            b = {1'b0, 8'h80};
        end else if (idx <= 6'd16) begin
            off = idx - 6'd1;
            b   = {1'b1, col_of(r1, off[3:0])};
        end else if (idx == 6'd17) begin
            b = {1'b0, 8'hC0};
        end else begin
            off = idx - 6'd18;
            b   = {1'b1, col_of(r2, off[3:0])};
        end
        return b;
    endfunction

    always_comb begin
        rows_changed = (bus.row_1 != snap1_q) || (bus.row_2 != snap2_q);
        phase_last   = E_LAST;
        if (phase_q == PH_HOLD)
            phase_last = (!rs_q && data_q == 8'h01) ? CLEAR_LAST : CMD_LAST;
        phase_end = (cnt_q == phase_last);
        last_byte = (state_q == ST_INIT) ? (idx_q == 6'd3) : (idx_q == 6'd33);
        idx_d     = idx_q + 6'd1;
        byte_d    = byte_sel(state_q == ST_FRAME, idx_d, snap1_q, snap2_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_POWERUP;
            phase_q <= PH_SETUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            force_q <= 1'b0;
            snap1_q <= '0;
            snap2_q <= '0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_POWERUP: begin
                    if (cnt_q == PU_END) begin
                        state_q          <= ST_INIT;
                        phase_q          <= PH_SETUP;
                        cnt_q            <= '0;
                        idx_q            <= '0;
                        {rs_q, data_q}   <= byte_sel(1'b0, 6'd0, snap1_q, snap2_q);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_IDLE: begin
                    if (rows_changed || force_q) begin
                        snap1_q        <= bus.row_1;
                        snap2_q        <= bus.row_2;
                        force_q        <= 1'b0;
                        state_q        <= ST_FRAME;
                        phase_q        <= PH_SETUP;
                        cnt_q          <= '0;
                        idx_q          <= '0;
                        ready_q        <= 1'b0;
                        {rs_q, data_q} <= byte_sel(1'b1, 6'd0, snap1_q, snap2_q);
                    end
                end
                default: begin
                    if (!phase_end) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= '0;
                        case (phase_q)
                            PH_SETUP: begin
                                phase_q <= PH_PULSE;
                                en_q    <= 1'b1;
                            end
                            PH_PULSE: begin
                                phase_q <= PH_HOLD;
                                en_q    <= 1'b0;
                            end
                            default: begin
                                if (last_byte) begin
                                    state_q <= ST_IDLE;
                                    ready_q <= 1'b1;
                                    if (state_q == ST_FRAME)
                                        done_q <= 1'b1;
                                    else
                                        force_q <= 1'b1;
                                end else begin
                                    idx_q          <= idx_d;
                                    phase_q        <= PH_SETUP;
                                    {rs_q, data_q} <= byte_d;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.lcd_en     = en_q;
    assign bus.lcd_rs     = rs_q;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_data   = data_q;
    assign bus.ready      = ready_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_lcd_row_writer.sv
// Directed plus randomized bench for lcd_row_writer; LCD write strobes are
// captured into a queue and compared against byte lists built from the rows.
module tb_lcd_row_writer;
    localparam int E   = 2;
    localparam int CMD = 4;
    localparam int CLR = 20;
    localparam int PU  = 50;
    localparam int BYTE_CYC  = 2 * E + CMD;
    localparam int CLR_CYC   = 2 * E + CLR;
    localparam int FIRST_EN  = PU + E + 1;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_row_writer_if bus ();

    lcd_row_writer #(
        .E_CYCLES(E), .CMD_WAIT(CMD), .CLEAR_WAIT(CLR), .POWERUP_WAIT(PU)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    ev_t        rises[$];
    int         done_cycs[$];
    int         cyc      = 0;
    int         done_cnt = 0;
    logic       prev_en  = 1'b0;
    logic [8:0] rise_byte = 9'h000;
    int         checks   = 0;
    int         errors   = 0;
    logic [8:0] fr[34];
    logic [7:0] init_bytes[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.lcd_en && !prev_en) begin
            rises.push_back('{bus.lcd_rs, bus.lcd_data, cyc});
            rise_byte = {bus.lcd_rs, bus.lcd_data};
        end
        if (!bus.lcd_en && prev_en && !rst)
            check("stable_at_pulse_end", {23'd0, bus.lcd_rs, bus.lcd_data}, {23'd0, rise_byte});
        if (bus.frame_done) begin
            done_cnt++;
            done_cycs.push_back(cyc);
        end
        prev_en = bus.lcd_en;
    end

    // Expected byte list of a frame, straight from the row layout.
    task automatic build_frame(input logic [127:0] r1, input logic [127:0] r2);
        fr[0]  = {1'b0, 8'h80};
        fr[17] = {1'b0, 8'hC0};
        for (int c = 0; c < 16; c++) begin
            fr[1 + c]  = {1'b1, r1[127 - 8 * c -: 8]};
            fr[18 + c] = {1'b1, r2[127 - 8 * c -: 8]};
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) check("timeout_frame_done", done_cnt, target);
    endtask

    task automatic wait_rises(input int target, input int budget);
        int n = 0;
        while (rises.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (rises.size() < target) check("timeout_en_pulses", rises.size(), target);
    endtask

    task automatic check_init(input int rel);
        check("first_en_cycle", rises[0].cyc - rel, FIRST_EN);
        for (int i = 0; i < 4; i++)
            check("init_byte", {23'd0, rises[i].rs, rises[i].data}, {23'd0, 1'b0, init_bytes[i]});
        check("gap_after_38", rises[1].cyc - rises[0].cyc, BYTE_CYC);
        check("gap_after_0C", rises[2].cyc - rises[1].cyc, BYTE_CYC);
        check("gap_after_01", rises[3].cyc - rises[2].cyc, CLR_CYC);
    endtask

    task automatic check_frame(input int base, input logic [127:0] r1, input logic [127:0] r2,
                               input int dcyc);
        build_frame(r1, r2);
        for (int i = 0; i < 34; i++)
            check("frame_byte", {23'd0, rises[base + i].rs, rises[base + i].data}, {23'd0, fr[i]});
        for (int i = 1; i < 34; i++)
            check("frame_gap", rises[base + i].cyc - rises[base + i - 1].cyc, BYTE_CYC);
        check("frame_done_timing", dcyc - rises[base].cyc, 34 * BYTE_CYC - E);
    endtask

    initial begin
        logic [127:0] apple;
        logic [127:0] unders;
        logic [127:0] r1;
        logic [127:0] r2;
        int rel;
        int d0;
        int d1;
        logic ready_ok;
        logic en_before;

        apple  = {"APPLE", {11{8'h20}}};
        unders = {16{8'h5F}};
        bus.row_1 = apple;
        bus.row_2 = unders;

        // Reset values, then power-up, init and the forced first frame.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_lcd_en", bus.lcd_en, 0);
        check("rst_lcd_rs", bus.lcd_rs, 0);
        check("rst_lcd_rw", bus.lcd_rw, 0);
        check("rst_lcd_data", bus.lcd_data, 0);
        check("rst_ready", bus.ready, 0);
        check("rst_frame_done", bus.frame_done, 0);
        rises.delete();
        rel = cyc;
        rst = 1'b0;
        wait_done(1, 3000);
        check("boot_pulse_count", rises.size(), 38);
        check_init(rel);
        check_frame(4, apple, unders, done_cycs[done_cycs.size() - 1]);
        check("apple_A", rises[5].data, 8'h41);
        @(negedge clk);
        check("ready_after_frame", bus.ready, 1);

        // Static rows: nothing written, ready held.
        rises.delete();
        ready_ok = 1'b1;
        repeat (2000) begin
            @(negedge clk);
            if (!bus.ready) ready_ok = 1'b0;
        end
        check("static_pulses", rises.size(), 0);
        check("static_ready", ready_ok, 1);

        // Row change during a frame lands in the following frame.
        rises.delete();
        d0 = done_cnt;
        bus.row_2 = {16{8'h2A}};
        wait_rises(5, 500);
        check("ready_low_in_frame", bus.ready, 0);
        r1 = apple;
        r1[127:120] = 8'h4D;
        bus.row_1 = r1;
        wait_done(d0 + 1, 1000);
        d1 = done_cycs[done_cycs.size() - 1];
        check_frame(0, apple, {16{8'h2A}}, d1);
        wait_done(d0 + 2, 1000);
        check("restart_latency", rises[34].cyc - d1, 1 + E);
        check("second_frame_M", rises[35].data, 8'h4D);
        check_frame(34, r1, {16{8'h2A}}, done_cycs[done_cycs.size() - 1]);

        // Random rows; every row carries a 0x01 character that must not get the clear wait.
        for (int k = 0; k < 4; k++) begin
            r1 = {$urandom, $urandom, $urandom, $urandom};
            r2 = {$urandom, $urandom, $urandom, $urandom};
            r1[7:0] = 8'h01;
            r2[8 * $urandom_range(0, 15) +: 8] = 8'h01;
            rises.delete();
            d0 = done_cnt;
            bus.row_1 = r1;
            bus.row_2 = r2;
            wait_done(d0 + 1, 1000);
            check("rand_pulse_count", rises.size(), 34);
            check_frame(0, r1, r2, done_cycs[done_cycs.size() - 1]);
        end

        // Reset while enable is high; zero rows still get a forced frame afterwards.
        rises.delete();
        bus.row_1 = '0;
        bus.row_2 = '0;
        wait_rises(3, 500);
        for (int n = 0; n < 20 && !bus.lcd_en; n++) @(negedge clk);
        en_before = bus.lcd_en;
        check("en_high_before_rst", en_before, 1);
        #2 rst = 1'b1;
        #1 check("rst_drops_en", bus.lcd_en, 0);
        repeat (2) @(negedge clk);
        rises.delete();
        d0 = done_cnt;
        rel = cyc;
        rst = 1'b0;
        wait_done(d0 + 1, 3000);
        check("reboot_pulse_count", rises.size(), 38);
        check_init(rel);
        check_frame(4, '0, '0, done_cycs[done_cycs.size() - 1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_row_writer.md
# lcd_row_writer

Consumer of the game's two 128-bit display rows. It converts `row_1`/`row_2` (16 ASCII characters each) into HD44780-compatible 8-bit parallel write cycles for a 16x2 character LCD. After reset it runs the controller power-up and init sequence, then rewrites the full display whenever the row contents change. One instance sits between the game core's display-row outputs and the LCD pins, for either the host or the player screen.

## Interface

- `E_CYCLES`, default 8: clock cycles for the data setup phase, and again for the enable-high phase.
- `CMD_WAIT`, default 500: clock cycles of enable-low hold after every byte except clear.
- `CLEAR_WAIT`, default 20000: clock cycles of enable-low hold after the clear-display command (0x01).
- `POWERUP_WAIT`, default 200000: clock cycles between reset release and the first byte.

- `clk` input 1: single system clock. All logic is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `row_1` input 128: top line. `[127:120]` is column 0 and `[7:0]` is column 15.
- `row_2` input 128: bottom line, same packing.
- `lcd_en` output 1: LCD enable strobe.
- `lcd_rs` output 1: register select. 0 = command, 1 = data.
- `lcd_rw` output 1: tied to 0 (write only).
- `lcd_data` output 8: LCD data bus.
- `ready` output 1: high in IDLE. Init is done and no frame is in progress.
- `frame_done` output 1: one-cycle pulse after the last byte of a frame finishes its hold.

## Operation

**States:** POWERUP → INIT → IDLE → FRAME → IDLE. Each byte, in INIT or FRAME, passes through three sub-phases: SETUP → PULSE → HOLD.

**Byte write:**
- SETUP: `lcd_rs` and `lcd_data` are driven and `lcd_en`=0, for `E_CYCLES` cycles.
- PULSE: `lcd_en`=1, for `E_CYCLES` cycles.
- HOLD: `lcd_en`=0, for `CMD_WAIT` cycles (`CLEAR_WAIT` after 0x01).
- `lcd_rs` and `lcd_data` stay stable from the start of SETUP to the end of HOLD.

**POWERUP:** count `POWERUP_WAIT` cycles, then enter INIT.

**INIT:** write commands 0x38, 0x0C, 0x01, 0x06 in that order, all with `rs`=0. Then go to IDLE and force one frame.

**IDLE:**
- `ready`=1.
- Compare `row_1`/`row_2` against the last-written snapshot.
- If they differ, or a frame is forced, capture both rows into the snapshot and enter FRAME on the next cycle.

**FRAME:** 34 bytes from the snapshot, in this order:
1. 0x80 (`rs`=0)
2. `row_1` columns 0–15 (`rs`=1)
3. 0xC0 (`rs`=0)
4. `row_2` columns 0–15 (`rs`=1)

Then pulse `frame_done` and return to IDLE.

**Input changes:**
- Rows that change during FRAME do not affect the frame in progress.
- A change still present on return to IDLE starts a new frame immediately.

**Character values:** bytes are passed through unmodified; no character translation.

**Counters:** the phase counter is wide enough for `max(POWERUP_WAIT, CLEAR_WAIT)`. The byte index is 0..33 and resets to 0 at the start of each frame.

## Timing

**Reset values** (asynchronous, while `rst`=1):
- `lcd_en`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00
- `ready`=0, `frame_done`=0
- snapshot cleared, state POWERUP with counter 0

**Startup latency:** the first SETUP begins `POWERUP_WAIT` cycles after the first rising edge with `rst`=0.

**Per-byte cost:** `2*E_CYCLES + CMD_WAIT` cycles, or `2*E_CYCLES + CLEAR_WAIT` for the clear command.

**Frame length:** `34*(2*E_CYCLES+CMD_WAIT)` cycles from FRAME entry to the `frame_done` pulse. `frame_done` asserts on the cycle after the final HOLD ends. `ready` rises on that same cycle.

**IDLE → FRAME:** 1 cycle (compare and capture, then first SETUP).

**Reset during operation:** reset during any phase, including PULSE, drops `lcd_en` immediately. After release, the full POWERUP and INIT sequence is repeated, and a frame is always written afterwards, even if the rows are unchanged.

**Output hygiene:** no glitches on `lcd_en`. All outputs are registered.

## Test plan

All scenarios use `E_CYCLES`=2, `CMD_WAIT`=4, `CLEAR_WAIT`=20, `POWERUP_WAIT`=50.

1. **Reset values.** Assert `rst` → all outputs are at their reset values. Release `rst` → `lcd_en` stays 0 for 52 cycles and first rises at cycle 53.
2. **Init sequence.** After reset → exactly 4 enable pulses with `rs`=0 and data 0x38, 0x0C, 0x01, 0x06. The gap after 0x01 is 20 cycles; the gaps after the others are 4.
3. **Frame content.**
   - Stimulus: `row_1`="APPLE" padded with 0x20; `row_2` all 0x5F ('_').
   - Required: 34 pulses carrying 0x80, 0x41, 0x50, 0x50, 0x4C, 0x45, eleven 0x20, 0xC0, then sixteen 0x5F.
   - `rs` pattern: 0, 1×16, 0, 1×16.
   - `frame_done` pulses once, 272 cycles after FRAME entry, and `ready` returns to 1.
4. **Static rows.** Hold the rows constant after a frame → no `lcd_en` activity for 2000 cycles and `ready` stays 1.
5. **Change during a frame.** Change `row_1` col 0 to 'M' (0x4D) while byte 5 is in progress → the current frame still emits 0x41. A second frame starts 1 cycle after `frame_done` and emits 0x4D.
6. **Reset during a frame.** Assert `rst` while `lcd_en`=1 → `lcd_en`=0 in the same cycle. After release, the 50-cycle wait, init and a full frame repeat.
